// File: rtl/terrain_scroller.sv
// rtl/terrain_scroller.sv - circular terrain row buffer rendered as VGA bands (option: TERRAIN_SCROLLER_COLLIDE_EN)
// Newest captured line is drawn in the top band; the optional collision check tests the line leaving the bottom.
module terrain_scroller #(
    parameter int ROWS  = 8,
    parameter int ROW_H = 60,
    parameter int WIDTH = 640
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [WIDTH-1:0] line_i,
    input  logic             scroll_i,
    input  logic [9:0]       pix_x_i,
    input  logic [9:0]       pix_y_i,
    input  logic             video_on_i,
    input  logic [9:0]       player_x_i,
    output logic             pixel_o,
    output logic [4:0]       rows_valid_o,
    output logic             collision_o
);
    localparam int          PTR_W    = $clog2(ROWS);
    localparam logic [10:0] SCREEN_H = 11'(ROWS * ROW_H);
    localparam logic [10:0] LINE_W   = 11'(WIDTH);
    localparam logic [4:0]  FILL_MAX = 5'(ROWS);

    logic [WIDTH-1:0] mem [ROWS];
    logic [PTR_W-1:0] wr_ptr;
    logic [4:0]       fill;
    logic [PTR_W-1:0] band;
    logic [PTR_W-1:0] slot;
    logic [WIDTH-1:0] row_data;
    logic             x_in;
    logic             y_in;
    logic             band_ok;
    logic             pixel_d;

    // Unwritten slots are masked by fill, so the array carries no reset.
    always_ff @(posedge clk_i) begin
        if (scroll_i) begin
            mem[wr_ptr] <= line_i;
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            wr_ptr <= '0;
            fill   <= '0;
        end else if (scroll_i) begin
            wr_ptr <= wr_ptr + 1'b1;
            if (fill != FILL_MAX) begin
                fill <= fill + 5'd1;
            end
        end
    end

    // Band index from a threshold chain instead of a divider.
    always_comb begin
        band = '0;
        for (int r = 1; r < ROWS; r++) begin
            if ({1'b0, pix_y_i} >= 11'(r * ROW_H)) begin
                band = PTR_W'(r);
            end
        end
    end

    assign slot     = wr_ptr - 1'b1 - band;
    assign row_data = mem[slot];
    assign band_ok  = 5'(band) < fill;
    assign x_in     = {1'b0, pix_x_i} < LINE_W;
    assign y_in     = {1'b0, pix_y_i} < SCREEN_H;
    assign pixel_d  = video_on_i & x_in & y_in & band_ok & row_data[pix_x_i];

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            pixel_o <= 1'b0;
        end else begin
            pixel_o <= pixel_d;
        end
    end

    assign rows_valid_o = fill;

`ifdef TERRAIN_SCROLLER_COLLIDE_EN
    logic [WIDTH-1:0] oldest;
    logic             player_in;

    // mem[wr_ptr] is the row about to be overwritten, i.e. the one leaving the bottom band.
    assign oldest    = mem[wr_ptr];
    assign player_in = {1'b0, player_x_i} < LINE_W;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            collision_o <= 1'b0;
        end else if (scroll_i && (fill == FILL_MAX) && player_in && oldest[player_x_i]) begin
            collision_o <= 1'b1;
        end
    end
`else
    logic unused_player_x;
    assign unused_player_x = ^player_x_i;
    assign collision_o     = 1'b0;
`endif

endmodule

// File: tb/tb_terrain_scroller.sv
// tb/tb_terrain_scroller.sv - directed self-checking bench for terrain_scroller
// Expected collision behaviour follows TERRAIN_SCROLLER_COLLIDE_EN as compiled.
module tb_terrain_scroller;
    logic         clk_i = 1'b0;
    logic         reset_i;
    logic [639:0] line_i;
    logic         scroll_i;
    logic [9:0]   pix_x_i;
    logic [9:0]   pix_y_i;
    logic         video_on_i;
    logic [9:0]   player_x_i;
    logic         pixel_o;
    logic [4:0]   rows_valid_o;
    logic         collision_o;

    int passed = 0;
    int total  = 0;
    logic [639:0] ln;
    logic         exp_col;

    terrain_scroller dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .line_i      (line_i),
        .scroll_i    (scroll_i),
        .pix_x_i     (pix_x_i),
        .pix_y_i     (pix_y_i),
        .video_on_i  (video_on_i),
        .player_x_i  (player_x_i),
        .pixel_o     (pixel_o),
        .rows_valid_o(rows_valid_o),
        .collision_o (collision_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    endtask

    task automatic do_reset();
        reset_i  = 1'b0;
        scroll_i = 1'b0;
        tick();
        tick();
        reset_i = 1'b1;
    endtask

    task automatic scroll(input logic [639:0] l);
        line_i   = l;
        scroll_i = 1'b1;
        tick();
        scroll_i = 1'b0;
    endtask

    task automatic probe(input string tag, input int x, input int y, input logic von, input logic exp);
        pix_x_i    = 10'(x);
        pix_y_i    = 10'(y);
        video_on_i = von;
        tick();
        chk(tag, 32'(pixel_o), 32'(exp));
    endtask

    initial begin
`ifdef TERRAIN_SCROLLER_COLLIDE_EN
        exp_col = 1'b1;
`else
        exp_col = 1'b0;
`endif
        reset_i    = 1'b0;
        line_i     = '0;
        scroll_i   = 1'b0;
        pix_x_i    = '0;
        pix_y_i    = '0;
        video_on_i = 1'b0;
        player_x_i = 10'd100;
        tick();
        chk("reset_pix", 32'(pixel_o), 0);
        chk("reset_rows", 32'(rows_valid_o), 0);
        chk("reset_col", 32'(collision_o), 0);
        reset_i = 1'b1;

        // Asynchronous reset in the middle of activity
        scroll({640{1'b1}});
        probe("pre_reset_pix", 0, 0, 1'b1, 1'b1);
        #2 reset_i = 1'b0;
        #1;
        chk("async_reset_pix", 32'(pixel_o), 0);
        chk("async_reset_rows", 32'(rows_valid_o), 0);
        chk("async_reset_col", 32'(collision_o), 0);
        tick();
        reset_i = 1'b1;
        for (int y = 0; y < 480; y += 60) begin
            probe($sformatf("blank_l_y%0d", y), 0, y, 1'b1, 1'b0);
            probe($sformatf("blank_r_y%0d", y), 639, y + 59, 1'b1, 1'b0);
        end

        // Single row
        ln = '0;
        ln[5] = 1'b1;
        scroll(ln);
        chk("single_rows", 32'(rows_valid_o), 1);
        probe("single_hit", 5, 0, 1'b1, 1'b1);
        probe("single_band_bottom", 5, 59, 1'b1, 1'b1);
        probe("single_other_col", 6, 0, 1'b1, 1'b0);
        probe("single_band1_invalid", 5, 60, 1'b1, 1'b0);
        probe("single_video_off", 5, 0, 1'b0, 1'b0);

        // Wrap with nine one-hot lines
        do_reset();
        for (int k = 0; k < 9; k++) begin
            ln = '0;
            ln[k] = 1'b1;
            scroll(ln);
        end
        chk("wrap_rows", 32'(rows_valid_o), 8);
        probe("wrap_band0_l8", 8, 0, 1'b1, 1'b1);
        probe("wrap_band1_l7", 7, 60, 1'b1, 1'b1);
        probe("wrap_band1_not_l8", 8, 60, 1'b1, 1'b0);
        probe("wrap_band7_l1", 1, 420, 1'b1, 1'b1);
        probe("wrap_band7_bottom_l1", 1, 479, 1'b1, 1'b1);
        for (int r = 0; r < 8; r++) begin
            probe($sformatf("wrap_l0_gone_b%0d", r), 0, r * 60, 1'b1, 1'b0);
        end

        // Lookup on the same edge as a capture sees the old newest row
        do_reset();
        scroll({640{1'b1}});
        pix_x_i    = 10'd0;
        pix_y_i    = 10'd0;
        video_on_i = 1'b1;
        line_i     = '0;
        scroll_i   = 1'b1;
        tick();
        scroll_i = 1'b0;
        chk("same_cycle_old", 32'(pixel_o), 1);
        chk("same_cycle_rows", 32'(rows_valid_o), 2);
        tick();
        chk("same_cycle_new", 32'(pixel_o), 0);

        // Out of range probes and collision on a full buffer
        do_reset();
        player_x_i = 10'd100;
        for (int k = 0; k < 8; k++) scroll({640{1'b1}});
        chk("full_rows", 32'(rows_valid_o), 8);
        chk("fill_no_col", 32'(collision_o), 0);
        probe("oor_x700", 700, 10, 1'b1, 1'b0);
        probe("oor_y480", 10, 480, 1'b1, 1'b0);
        probe("oor_y1023", 10, 1023, 1'b1, 1'b0);
        probe("corner_639_479", 639, 479, 1'b1, 1'b1);
        probe("corner_0_0", 0, 0, 1'b1, 1'b1);
        player_x_i = 10'd1023;
        scroll({640{1'b1}});
        chk("player_oor_no_col", 32'(collision_o), 0);
        chk("full_rows_sat", 32'(rows_valid_o), 8);
        player_x_i = 10'd100;
        scroll('0);
        chk("col_rise", 32'(collision_o), 32'(exp_col));
        for (int k = 0; k < 10; k++) scroll('0);
        chk("col_sticky", 32'(collision_o), 32'(exp_col));
        probe("zero_rows_blank", 100, 0, 1'b1, 1'b0);
        do_reset();
        chk("col_reset", 32'(collision_o), 0);
        chk("rows_after_reset", 32'(rows_valid_o), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/terrain_scroller.md
# terrain_scroller

Row buffer that sits directly downstream of the random line generator. It captures a 640-bit terrain line on every scroll pulse into a circular buffer of ROWS lines. It renders the buffered lines as horizontal bands to the VGA pixel path, with the newest line at the top of the screen. An optional player-collision check is evaluated against the line leaving the bottom of the screen.

## Interface
Parameters:
- ROWS, 8, number of buffered lines; power of two, 2..16
- ROW_H, 60, screen height in pixels of one buffered line; ROWS*ROW_H ≤ 1024
- WIDTH, 640, bits per line and visible pixels per scanline

Ports:
- clk_i  input  1  pixel/system clock
- reset_i  input  1  reset, asynchronous, active-low
- line_i  input  WIDTH  current line from the generator; bit k maps to screen column k (bit 0 = leftmost)
- scroll_i  input  1  single-cycle pulse: capture line_i as the newest row
- pix_x_i  input  10  current pixel column from the VGA timing block
- pix_y_i  input  10  current pixel row
- video_on_i  input  1  active-video qualifier
- player_x_i  input  10  player column; used only when collision is compiled in
- pixel_o  output  1  registered terrain pixel for (pix_x_i, pix_y_i)
- rows_valid_o  output  5  number of rows written since reset, saturating at ROWS
- collision_o  output  1  sticky collision flag

Reset clock and polarity: reset reset_i, asynchronous, active-low; clock clk_i.

## Operation
- Storage: mem[0..ROWS-1], each WIDTH bits; write pointer wr_ptr, log2(ROWS) bits; fill counter fill, 0..ROWS. mem contents need no reset because fill hides unwritten slots.
- Capture on a clk_i edge with scroll_i=1:
  - mem[wr_ptr] <= line_i
  - wr_ptr <= (wr_ptr+1) mod ROWS; wraps silently
  - fill <= min(fill+1, ROWS)
- Screen mapping: screen band r = floor(pix_y_i / ROW_H), r in 0..ROWS-1.
  - Band r displays slot (wr_ptr-1-r) mod ROWS: band 0 is the newest row, band ROWS-1 the oldest.
  - Band r is valid only when r < fill.
- pixel_o is 1 only when all of the following hold; otherwise 0:
  - video_on_i=1
  - pix_y_i < ROWS*ROW_H
  - pix_x_i < WIDTH
  - band valid
  - mem[slot][pix_x_i]=1
- Division by ROW_H is implemented as a compare chain or equivalent. Only the result is specified.
- rows_valid_o = fill.
- Simultaneous scroll_i and pixel lookup: the lookup uses pre-capture state (old wr_ptr, old mem, old fill). The new row becomes visible from the next cycle.
- Reset mid-operation: fill, wr_ptr and all outputs clear immediately. The screen renders blank until the next scroll_i.

## Timing
- Reset values: pixel_o=0, rows_valid_o=0, collision_o=0, wr_ptr=0, fill=0.
- pixel_o latency: 1 cycle from pix_x_i/pix_y_i/video_on_i. The VGA block delays hsync/vsync by 1 cycle to match.
- rows_valid_o updates on the same edge that captures the row.
- collision_o rises 1 cycle after the qualifying scroll_i edge.
- scroll_i held high for multiple cycles captures line_i on every cycle. The upstream generator guarantees one pulse per scroll step.

## Configuration
- Macro: TERRAIN_SCROLLER_COLLIDE_EN.
- Defined: on each scroll_i with fill==ROWS, the oldest row mem[wr_ptr] (the one being overwritten and leaving the bottom band) is checked before overwrite.
  - If player_x_i < WIDTH and mem[wr_ptr][player_x_i]=1, collision_o is set.
  - collision_o is sticky and cleared only by reset_i.
  - player_x_i ≥ WIDTH never collides.
- Undefined: collision_o is tied 0 and player_x_i is ignored. No collision logic is synthesized.

## Test plan
- Reset check: assert reset_i=0 mid-stream -> pixel_o=0, rows_valid_o=0 and collision_o=0 immediately. Sweep video_on_i=1 over the whole screen -> pixel_o stays 0.
- Single row: line_i has only bit 5 set, one scroll_i pulse -> rows_valid_o=1. Probe (5,0) -> pixel_o=1 one cycle later. Probes (6,0), (5,60) and (5,0) with video_on_i=0 -> pixel_o=0.
- Wrap: 9 pulses with line Lk having only bit k set (k=0..8) -> rows_valid_o=8. Band 0 shows bit 8 at x=8; band 7 (y=420) shows bit 1 at x=1; L0 is gone (x=0, all bands: pixel_o=0).
- Same-cycle scroll and lookup: one row of all ones, then scroll_i with line_i=0 while probing (0,0) -> pixel_o=1 on the next cycle, 0 on the cycle after for the same probe.
- Out of range: buffer full of all ones; probe (700,10) and (10,480) -> pixel_o=0; probe (639,479) -> pixel_o=1.
- Collision with macro defined: 8 scrolls of all-ones lines, player_x_i=100, ninth scroll_i -> collision_o=1 one cycle later and stays 1 across further scrolls of zero lines until reset. Same stimulus with the macro undefined -> collision_o stays 0.
